// File: rtl/axistream_to_axi_ax_decoder_if.sv
// Stream-in / AXI-request-out bundle for the AX decoder.
// "slave" is the decoder's view: it consumes the stream and drives AR/AW.
// "master" is the environment's view: it produces the stream and consumes AR/AW.
interface axistream_to_axi_ax_decoder_if #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 32,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned LOCK_WIDTH = 2,
   parameter int unsigned USER_WIDTH = 64
) ();
   logic [DATA_WIDTH-1:0] stream_tdata;
   logic                  stream_tlast;
   logic                  stream_tvalid;
   logic                  stream_tready;

   logic [ID_WIDTH-1:0]   AXIM_arid;
   logic [ADDR_WIDTH-1:0] AXIM_araddr;
   logic [BURST_LEN-1:0]  AXIM_arlen;
   logic [2:0]            AXIM_arsize;
   logic [1:0]            AXIM_arburst;
   logic [LOCK_WIDTH-1:0] AXIM_arlock;
   logic [3:0]            AXIM_arcache;
   logic [2:0]            AXIM_arprot;
   logic [3:0]            AXIM_arregion;
   logic [3:0]            AXIM_arqos;
   logic [USER_WIDTH-1:0] AXIM_aruser;
   logic                  AXIM_arvalid;
   logic                  AXIM_arready;

   logic [ID_WIDTH-1:0]   AXIM_awid;
   logic [ADDR_WIDTH-1:0] AXIM_awaddr;
   logic [BURST_LEN-1:0]  AXIM_awlen;
   logic [2:0]            AXIM_awsize;
   logic [1:0]            AXIM_awburst;
   logic [LOCK_WIDTH-1:0] AXIM_awlock;
   logic [3:0]            AXIM_awcache;
   logic [2:0]            AXIM_awprot;
   logic [3:0]            AXIM_awregion;
   logic [3:0]            AXIM_awqos;
   logic [USER_WIDTH-1:0] AXIM_awuser;
   logic                  AXIM_awvalid;
   logic                  AXIM_awready;

   modport master (
      output stream_tdata, stream_tlast, stream_tvalid,
      input  stream_tready,
      input  AXIM_arid, AXIM_araddr, AXIM_arlen, AXIM_arsize, AXIM_arburst, AXIM_arlock,
      input  AXIM_arcache, AXIM_arprot, AXIM_arregion, AXIM_arqos, AXIM_aruser, AXIM_arvalid,
      output AXIM_arready,
      input  AXIM_awid, AXIM_awaddr, AXIM_awlen, AXIM_awsize, AXIM_awburst, AXIM_awlock,
      input  AXIM_awcache, AXIM_awprot, AXIM_awregion, AXIM_awqos, AXIM_awuser, AXIM_awvalid,
      output AXIM_awready
   );

   modport slave (
      input  stream_tdata, stream_tlast, stream_tvalid,
      output stream_tready,
      output AXIM_arid, AXIM_araddr, AXIM_arlen, AXIM_arsize, AXIM_arburst, AXIM_arlock,
      output AXIM_arcache, AXIM_arprot, AXIM_arregion, AXIM_arqos, AXIM_aruser, AXIM_arvalid,
      input  AXIM_arready,
      output AXIM_awid, AXIM_awaddr, AXIM_awlen, AXIM_awsize, AXIM_awburst, AXIM_awlock,
      output AXIM_awcache, AXIM_awprot, AXIM_awregion, AXIM_awqos, AXIM_awuser, AXIM_awvalid,
      input  AXIM_awready
   );
endinterface

// File: rtl/axistream_to_axi_ax_decoder.sv
// Reassembles multi-beat AR/AW header records from a stream and replays them as AXI requests.
// Malformed records (short, long, bad type) are dropped and counted.
module axistream_to_axi_ax_decoder #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 32,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned LOCK_WIDTH = 2,
   parameter int unsigned USER_WIDTH = 64,
   parameter int unsigned TYPE_WIDTH = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   axistream_to_axi_ax_decoder_if.slave bus,
   output logic                 err_pulse,
   output logic [CNT_WIDTH-1:0] ar_count,
   output logic [CNT_WIDTH-1:0] aw_count,
   output logic [CNT_WIDTH-1:0] err_count
);
   localparam int unsigned FLD_BITS = ID_WIDTH + ADDR_WIDTH + BURST_LEN + 3 + 2 + LOCK_WIDTH
                                      + 4 + 3 + 4 + 4 + USER_WIDTH;
   localparam int unsigned HDR_BITS = TYPE_WIDTH + FLD_BITS;
   localparam int unsigned BEATS    = (HDR_BITS + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int unsigned BUF_BITS = BEATS * DATA_WIDTH;
   localparam int unsigned CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(BEATS - 1);

   // Field offsets inside a slot (type field stripped).
   localparam int unsigned F_ADDR   = ID_WIDTH;
   localparam int unsigned F_LEN    = F_ADDR + ADDR_WIDTH;
   localparam int unsigned F_SIZE   = F_LEN + BURST_LEN;
   localparam int unsigned F_BURST  = F_SIZE + 3;
   localparam int unsigned F_LOCK   = F_BURST + 2;
   localparam int unsigned F_CACHE  = F_LOCK + LOCK_WIDTH;
   localparam int unsigned F_PROT   = F_CACHE + 4;
   localparam int unsigned F_REGION = F_PROT + 3;
   localparam int unsigned F_QOS    = F_REGION + 4;
   localparam int unsigned F_USER   = F_QOS + 4;

   typedef enum logic [0:0] {StCollect, StDiscard} state_e;

   state_e                  state_q, state_d;
   logic [CNT_BITS-1:0]     cnt_q, cnt_d;
   logic [TYPE_WIDTH-1:0]   type_q, type_d;
   logic [BUF_BITS-1:0]     buf_q, buf_d;
   logic                    ar_vld_q, ar_vld_d, aw_vld_q, aw_vld_d;
   logic [FLD_BITS-1:0]     ar_fld_q, ar_fld_d, aw_fld_q, aw_fld_d;
   logic                    err_q, err_d;
   logic [CNT_WIDTH-1:0]    ar_cnt_q, ar_cnt_d, aw_cnt_q, aw_cnt_d, err_cnt_q, err_cnt_d;

   logic [TYPE_WIDTH-1:0]   rec_type;
   logic                    is_ar, is_aw, ar_full, aw_full, at_last, tready, beat;
   logic                    load_ar, load_aw, drop;
   logic [BUF_BITS-1:0]     rec;
   logic                    unused_bits;

   // Receive FSM, slot management and statistics next-state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      type_d    = type_q;
      buf_d     = buf_q;
      load_ar   = 1'b0;
      load_aw   = 1'b0;
      drop      = 1'b0;

      // On beat 0 the type is still on the wire, not yet latched.
      rec_type = (cnt_q == '0) ? bus.stream_tdata[TYPE_WIDTH-1:0] : type_q;
      is_ar    = (rec_type == '0);
      is_aw    = (rec_type == TYPE_WIDTH'(1));
      ar_full  = ar_vld_q & ~bus.AXIM_arready;
      aw_full  = aw_vld_q & ~bus.AXIM_awready;
      at_last  = (state_q == StCollect) && (cnt_q == LAST_IDX);
      // Only the final beat of a record can be stalled, and only by its own slot.
      tready   = !(at_last && ((is_ar && ar_full) || (is_aw && aw_full)));
      beat     = bus.stream_tvalid && tready;

      rec = buf_q;
      rec[(BEATS-1)*DATA_WIDTH +: DATA_WIDTH] = bus.stream_tdata;

      if (beat) begin
         unique case (state_q)
            StCollect: begin
               if (cnt_q == '0) type_d = bus.stream_tdata[TYPE_WIDTH-1:0];
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  if (!bus.stream_tlast) begin
                     drop    = 1'b1;
                     state_d = StDiscard;
                  end else if (is_ar) begin
                     load_ar = 1'b1;
                  end else if (is_aw) begin
                     load_aw = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
               end else if (bus.stream_tlast) begin
                  drop  = 1'b1;
                  cnt_d = '0;
               end else begin
                  buf_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.stream_tdata;
                  cnt_d = cnt_q + CNT_BITS'(1);
               end
            end
            StDiscard: begin
               if (bus.stream_tlast) state_d = StCollect;
            end
            default: state_d = StCollect;
         endcase
      end

      // A load in the same cycle as a drain keeps valid high with the new fields.
      ar_vld_d = load_ar | ar_full;
      aw_vld_d = load_aw | aw_full;
      ar_fld_d = load_ar ? rec[HDR_BITS-1:TYPE_WIDTH] : ar_fld_q;
      aw_fld_d = load_aw ? rec[HDR_BITS-1:TYPE_WIDTH] : aw_fld_q;
      err_d    = drop;

      ar_cnt_d  = (load_ar && ar_cnt_q != '1) ? ar_cnt_q + CNT_WIDTH'(1) : ar_cnt_q;
      aw_cnt_d  = (load_aw && aw_cnt_q != '1) ? aw_cnt_q + CNT_WIDTH'(1) : aw_cnt_q;
      err_cnt_d = (drop && err_cnt_q != '1) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
   end

   assign unused_bits = ^{rec[BUF_BITS-1:HDR_BITS], rec[TYPE_WIDTH-1:0]};

   // All state registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StCollect;
         cnt_q     <= '0;
         type_q    <= '0;
         buf_q     <= '0;
         ar_vld_q  <= 1'b0;
         aw_vld_q  <= 1'b0;
         ar_fld_q  <= '0;
         aw_fld_q  <= '0;
         err_q     <= 1'b0;
         ar_cnt_q  <= '0;
         aw_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         type_q    <= type_d;
         buf_q     <= buf_d;
         ar_vld_q  <= ar_vld_d;
         aw_vld_q  <= aw_vld_d;
         ar_fld_q  <= ar_fld_d;
         aw_fld_q  <= aw_fld_d;
         err_q     <= err_d;
         ar_cnt_q  <= ar_cnt_d;
         aw_cnt_q  <= aw_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.stream_tready = tready;

   assign bus.AXIM_arvalid  = ar_vld_q;
   assign bus.AXIM_arid     = ar_fld_q[0 +: ID_WIDTH];
   assign bus.AXIM_araddr   = ar_fld_q[F_ADDR +: ADDR_WIDTH];
   assign bus.AXIM_arlen    = ar_fld_q[F_LEN +: BURST_LEN];
   assign bus.AXIM_arsize   = ar_fld_q[F_SIZE +: 3];
   assign bus.AXIM_arburst  = ar_fld_q[F_BURST +: 2];
   assign bus.AXIM_arlock   = ar_fld_q[F_LOCK +: LOCK_WIDTH];
   assign bus.AXIM_arcache  = ar_fld_q[F_CACHE +: 4];
   assign bus.AXIM_arprot   = ar_fld_q[F_PROT +: 3];
   assign bus.AXIM_arregion = ar_fld_q[F_REGION +: 4];
   assign bus.AXIM_arqos    = ar_fld_q[F_QOS +: 4];
   assign bus.AXIM_aruser   = ar_fld_q[F_USER +: USER_WIDTH];

   assign bus.AXIM_awvalid  = aw_vld_q;
   assign bus.AXIM_awid     = aw_fld_q[0 +: ID_WIDTH];
   assign bus.AXIM_awaddr   = aw_fld_q[F_ADDR +: ADDR_WIDTH];
   assign bus.AXIM_awlen    = aw_fld_q[F_LEN +: BURST_LEN];
   assign bus.AXIM_awsize   = aw_fld_q[F_SIZE +: 3];
   assign bus.AXIM_awburst  = aw_fld_q[F_BURST +: 2];
   assign bus.AXIM_awlock   = aw_fld_q[F_LOCK +: LOCK_WIDTH];
   assign bus.AXIM_awcache  = aw_fld_q[F_CACHE +: 4];
   assign bus.AXIM_awprot   = aw_fld_q[F_PROT +: 3];
   assign bus.AXIM_awregion = aw_fld_q[F_REGION +: 4];
   assign bus.AXIM_awqos    = aw_fld_q[F_QOS +: 4];
   assign bus.AXIM_awuser   = aw_fld_q[F_USER +: USER_WIDTH];

   assign err_pulse = err_q;
   assign ar_count  = ar_cnt_q;
   assign aw_count  = aw_cnt_q;
   assign err_count = err_cnt_q;
endmodule

// File: tb/tb_axistream_to_axi_ax_decoder.sv
// Scenario bench for axistream_to_axi_ax_decoder: records are built from fields,
// expected AR/AW requests are queued on send and checked when the handshake fires.
module tb_axistream_to_axi_ax_decoder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        err_pulse;
   logic [15:0] ar_count, aw_count, err_count;

   axistream_to_axi_ax_decoder_if bus ();

   axistream_to_axi_ax_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .err_pulse (err_pulse),
      .ar_count  (ar_count),
      .aw_count  (aw_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int err_seen = 0;
   int exp_ar = 0;
   int exp_aw = 0;
   int exp_err = 0;
   logic [189:0] ar_q[$];
   logic [189:0] aw_q[$];

   // Header layout, LSB first: type,id,addr,len,size,burst,lock,cache,prot,region,qos,user.
   function automatic logic [255:0] mk(input logic t, input logic [31:0] id,
                                       input logic [63:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst,
                                       input logic [1:0] lock, input logic [3:0] cache,
                                       input logic [2:0] prot, input logic [3:0] region,
                                       input logic [3:0] qos, input logic [63:0] user);
      logic [255:0] h;
      h = {$urandom, $urandom};  // padding above bit 190 must be ignored
      h <<= 191;
      h[190:0] = {user, qos, region, prot, cache, lock, burst, size, len, addr, id, t};
      return h;
   endfunction

   function automatic logic [255:0] rnd_hdr(input logic t);
      return mk(t, $urandom, {$urandom, $urandom}, 8'($urandom), 3'($urandom), 2'($urandom),
                2'($urandom), 4'($urandom), 3'($urandom), 4'($urandom), 4'($urandom),
                {$urandom, $urandom});
   endfunction

   // Handshakes observed at the negedge before the edge on which they complete.
   always @(negedge clk) begin
      logic [189:0] obs, exp_v;
      if (!reset) begin
         if (err_pulse) err_seen++;
         if (bus.AXIM_arvalid && bus.AXIM_arready) begin
            obs = {bus.AXIM_aruser, bus.AXIM_arqos, bus.AXIM_arregion, bus.AXIM_arprot,
                   bus.AXIM_arcache, bus.AXIM_arlock, bus.AXIM_arburst, bus.AXIM_arsize,
                   bus.AXIM_arlen, bus.AXIM_araddr, bus.AXIM_arid};
            total++;
            if (ar_q.size() == 0) begin
               bad++;
               $display("FAIL ar_unexpected got=%h required=none", obs);
            end else begin
               exp_v = ar_q.pop_front();
               if (obs !== exp_v) begin
                  bad++;
                  $display("FAIL ar_fields got=%h required=%h", obs, exp_v);
               end
            end
         end
         if (bus.AXIM_awvalid && bus.AXIM_awready) begin
            obs = {bus.AXIM_awuser, bus.AXIM_awqos, bus.AXIM_awregion, bus.AXIM_awprot,
                   bus.AXIM_awcache, bus.AXIM_awlock, bus.AXIM_awburst, bus.AXIM_awsize,
                   bus.AXIM_awlen, bus.AXIM_awaddr, bus.AXIM_awid};
            total++;
            if (aw_q.size() == 0) begin
               bad++;
               $display("FAIL aw_unexpected got=%h required=none", obs);
            end else begin
               exp_v = aw_q.pop_front();
               if (obs !== exp_v) begin
                  bad++;
                  $display("FAIL aw_fields got=%h required=%h", obs, exp_v);
               end
            end
         end
      end
   end

   // Drive one beat (called at posedge+1) and return at posedge+1 after it is accepted.
   task automatic send_beat(input logic [127:0] d, input logic l);
      bus.stream_tdata  = d;
      bus.stream_tlast  = l;
      bus.stream_tvalid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.stream_tready) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      total++;
      bad++;
      $display("FAIL beat_accept_timeout got=tready_low required=accept");
      bus.stream_tvalid = 1'b0;
   endtask

   task automatic send_rec(input logic [255:0] h, input int nbeats);
      logic [127:0] d;
      for (int b = 0; b < nbeats; b++) begin
         d = (b < 2) ? h[b*128 +: 128] : {$urandom, $urandom, $urandom, $urandom};
         send_beat(d, b == nbeats - 1);
      end
      bus.stream_tvalid = 1'b0;
      bus.stream_tlast  = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while ((ar_q.size() != 0 || aw_q.size() != 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (ar_q.size() != 0 || aw_q.size() != 0) begin
         bad++;
         $display("FAIL %s_drain got=ar%0d_aw%0d pending required=0", name, ar_q.size(),
                  aw_q.size());
      end
   endtask

   task automatic check_counts(input string name);
      total++;
      if (ar_count !== 16'(exp_ar) || aw_count !== 16'(exp_aw) || err_count !== 16'(exp_err))
      begin
         bad++;
         $display("FAIL %s_counts got=ar%0d_aw%0d_err%0d required=ar%0d_aw%0d_err%0d", name,
                  ar_count, aw_count, err_count, exp_ar, exp_aw, exp_err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (bus.stream_tready !== 1'b1) begin
         bad++;
         $display("FAIL reset_tready got=%b required=1", bus.stream_tready);
      end
      total++;
      if (bus.AXIM_arvalid !== 1'b0 || bus.AXIM_awvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%b%b required=00", bus.AXIM_arvalid, bus.AXIM_awvalid);
      end
      total++;
      if (bus.AXIM_araddr !== 64'h0 || bus.AXIM_awid !== 32'h0 || bus.AXIM_aruser !== 64'h0) begin
         bad++;
         $display("FAIL reset_fields got=%h_%h_%h required=0", bus.AXIM_araddr, bus.AXIM_awid,
                  bus.AXIM_aruser);
      end
      total++;
      if (err_pulse !== 1'b0) begin
         bad++;
         $display("FAIL reset_err_pulse got=%b required=0", err_pulse);
      end
      check_counts("reset");
      @(posedge clk);
      #1;
   endtask

   task automatic test_ar_basic();
      logic [255:0] h;
      bus.AXIM_arready = 1'b1;
      h = mk(1'b0, 32'h5, 64'h1000_0040, 8'd3, 3'd2, 2'd1, 2'd0, 4'h3, 3'd2, 4'h1, 4'h7,
             64'hDEAD_BEEF_0123_4567);
      ar_q.push_back(h[190:1]);
      send_rec(h, 2);
      @(negedge clk);
      total++;
      if (bus.AXIM_arvalid !== 1'b1 || bus.AXIM_awvalid !== 1'b0) begin
         bad++;
         $display("FAIL ar_latency got=ar%b_aw%b required=ar1_aw0", bus.AXIM_arvalid,
                  bus.AXIM_awvalid);
      end
      exp_ar++;
      wait_empty("ar_basic");
      check_counts("ar_basic");
   endtask

   task automatic test_aw_backpressure();
      logic [255:0] ha, hb;
      bus.AXIM_awready = 1'b0;
      ha = rnd_hdr(1'b1);
      hb = rnd_hdr(1'b1);
      aw_q.push_back(ha[190:1]);
      send_rec(ha, 2);
      aw_q.push_back(hb[190:1]);
      send_beat(hb[127:0], 1'b0);
      bus.stream_tdata  = hb[255:128];
      bus.stream_tlast  = 1'b1;
      bus.stream_tvalid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.stream_tready !== 1'b0) begin
         bad++;
         $display("FAIL bp_stall_start got=%b required=0", bus.stream_tready);
      end
      repeat (8) @(posedge clk);
      @(negedge clk);
      total++;
      if (bus.stream_tready !== 1'b0 || bus.AXIM_awvalid !== 1'b1) begin
         bad++;
         $display("FAIL bp_stall_hold got=tready%b_awvalid%b required=tready0_awvalid1",
                  bus.stream_tready, bus.AXIM_awvalid);
      end
      @(posedge clk);
      #1;
      bus.AXIM_awready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.stream_tready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release got=%b required=1", bus.stream_tready);
      end
      @(posedge clk);
      #1;
      bus.stream_tvalid = 1'b0;
      bus.stream_tlast  = 1'b0;
      @(negedge clk);
      total++;
      if (bus.AXIM_awvalid !== 1'b1) begin
         bad++;
         $display("FAIL bp_reload_valid got=%b required=1", bus.AXIM_awvalid);
      end
      exp_aw += 2;
      wait_empty("aw_backpressure");
      check_counts("aw_backpressure");
   endtask

   task automatic test_back_to_back();
      logic [255:0] hr, hw;
      bus.AXIM_arready = 1'b0;
      bus.AXIM_awready = 1'b0;
      hr = rnd_hdr(1'b0);
      hw = rnd_hdr(1'b1);
      ar_q.push_back(hr[190:1]);
      aw_q.push_back(hw[190:1]);
      send_rec(hr, 2);
      send_rec(hw, 2);
      @(negedge clk);
      total++;
      if ({bus.AXIM_arvalid, bus.AXIM_awvalid} !== 2'b11) begin
         bad++;
         $display("FAIL b2b_both_valid got=%b%b required=11", bus.AXIM_arvalid,
                  bus.AXIM_awvalid);
      end
      @(posedge clk);
      #1;
      bus.AXIM_awready = 1'b1;
      @(posedge clk);
      #1;
      bus.AXIM_awready = 1'b0;
      @(negedge clk);
      total++;
      if ({bus.AXIM_arvalid, bus.AXIM_awvalid} !== 2'b10 || aw_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_aw_first got=%b%b_q%0d required=10_q0", bus.AXIM_arvalid,
                  bus.AXIM_awvalid, aw_q.size());
      end
      @(posedge clk);
      #1;
      bus.AXIM_arready = 1'b1;
      exp_ar++;
      exp_aw++;
      wait_empty("back_to_back");
      check_counts("back_to_back");
   endtask

   task automatic test_short_record();
      logic [255:0] h;
      bus.AXIM_arready = 1'b1;
      bus.AXIM_awready = 1'b1;
      h = rnd_hdr(1'b0);
      send_rec(h, 1);
      exp_err++;
      @(negedge clk);
      total++;
      if (err_pulse !== 1'b1 || bus.AXIM_arvalid !== 1'b0) begin
         bad++;
         $display("FAIL short_err_pulse got=err%b_ar%b required=err1_ar0", err_pulse,
                  bus.AXIM_arvalid);
      end
      @(negedge clk);
      total++;
      if (err_pulse !== 1'b0) begin
         bad++;
         $display("FAIL short_err_width got=%b required=0", err_pulse);
      end
      h = rnd_hdr(1'b0);
      ar_q.push_back(h[190:1]);
      @(posedge clk);
      #1;
      send_rec(h, 2);
      exp_ar++;
      wait_empty("short_record");
      check_counts("short_record");
   endtask

   task automatic test_long_record();
      logic [255:0] h;
      h = rnd_hdr(1'b0);
      send_rec(h, 4);
      exp_err++;
      h = rnd_hdr(1'b1);
      aw_q.push_back(h[190:1]);
      send_rec(h, 2);
      exp_aw++;
      wait_empty("long_record");
      check_counts("long_record");
      total++;
      if (err_seen != exp_err) begin
         bad++;
         $display("FAIL err_pulse_total got=%0d required=%0d", err_seen, exp_err);
      end
   endtask

   task automatic test_reset_mid_record();
      logic [255:0] h;
      h = rnd_hdr(1'b1);
      send_beat(h[127:0], 1'b0);
      bus.stream_tvalid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_ar = 0;
      exp_aw = 0;
      exp_err = 0;
      err_seen = 0;
      // A leftover beat 1 must not complete the aborted record.
      send_beat(h[255:128], 1'b1);
      bus.stream_tvalid = 1'b0;
      bus.stream_tlast  = 1'b0;
      exp_err++;
      @(negedge clk);
      total++;
      if (bus.AXIM_awvalid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_awvalid got=%b required=0", bus.AXIM_awvalid);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_err = 0;
      err_seen = 0;
      check_counts("mid_reset_cleared");
      h = rnd_hdr(1'b1);
      aw_q.push_back(h[190:1]);
      send_rec(h, 2);
      exp_aw++;
      wait_empty("mid_reset");
      check_counts("mid_reset");
   endtask

   initial begin
      bus.stream_tdata  = '0;
      bus.stream_tlast  = 1'b0;
      bus.stream_tvalid = 1'b0;
      bus.AXIM_arready  = 1'b0;
      bus.AXIM_awready  = 1'b0;
      test_reset();
      test_ar_basic();
      test_aw_backpressure();
      test_back_to_back();
      test_short_record();
      test_long_record();
      test_reset_mid_record();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
